char_buffer_writer: RTL
=======================

Name: char_buffer_writer

Overview:
- Writer side of the on-screen text buffer: accepts a byte stream (ASCII characters plus control codes) over a valid/ready handshake and writes character codes into the 256-entry character RAM.
- The text overlay reads that RAM back using the 8-bit address {row[2:0], col[4:0]}.
- Maintains a 32x8 text cursor.
- Clears the buffer to blanks after reset and on form-feed.

Parameters:
- COLS, 32, characters per row; the address column field is fixed at 5 bits.
- ROWS, 8, text rows; the address row field is fixed at 3 bits.
- BLANK_CHAR, 8'h20, code written by clear and backspace.

Ports:
- pclk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  character or control byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte this cycle.
- wr_en  output  1  character RAM write strobe.
- wr_addr  output  8  RAM address {row[2:0], col[4:0]}.
- wr_data  output  8  character code to write.
- cursor_x  output  5  current cursor column.
- cursor_y  output  3  current cursor row.
- busy  output  1  high while a clear is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - state=CLEAR, clear counter=0, cursor=(0,0).
  - wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=1.
  - Asserting rst mid-clear or mid-stream aborts immediately; after release the clear restarts from address 0.
- States: CLEAR, IDLE.
- in_ready is combinational: 1 only in IDLE. A byte is accepted on a pclk edge where in_valid && in_ready.
- All write-port outputs are registered. wr_en/wr_addr/wr_data appear one cycle after the accepting edge. wr_en is a 1-cycle pulse per write.
- CLEAR state:
  - wr_en=1 for exactly 256 consecutive cycles, wr_addr=0,1,...,255, wr_data=BLANK_CHAR.
  - On the cycle after address 255 is driven: state goes to IDLE, busy=0, wr_en=0.
  - The cursor is held at (0,0).
- IDLE, byte decode on acceptance (cursor updates on the same edge as the registered write):
  - 0x20..0x7E printable:
    - Write in_data at the current cursor, then advance the cursor.
    - col 31 wraps to col 0 and row+1.
    - (31,7) wraps to (0,0). There is no scrolling.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: row=row+1 mod 8, col unchanged, no write.
  - 0x08 BS:
    - If col>0: col-1.
    - Else if row>0: row-1, col=31.
    - Then write BLANK_CHAR at the new cursor position.
    - At (0,0): no cursor move, no write.
  - 0x0C FF: cursor=(0,0), enter CLEAR (full 256-cycle clear, busy=1). in_ready drops on the next cycle.
  - Any other code: accepted and consumed, no write, cursor unchanged.
- Back-to-back acceptance is allowed in IDLE: one byte per cycle, giving up to one write per cycle.
- Arithmetic:
  - Cursor fields wrap modulo their width.
  - wr_addr = {cursor_y, cursor_x} sampled before the advance for printable bytes, and after the move for BS.
- in_data is ignored whenever in_ready=0. The upstream must hold the byte until it is accepted.
- cursor_x/cursor_y are registers and always reflect the next write position.

Test Plan:
1. Reset release -> busy=1, in_ready=0. wr_en high for exactly 256 cycles with addresses 0..255 and data 8'h20. Then busy=0, in_ready=1, cursor=(0,0).
2. After clear, send "AB" back-to-back -> writes (addr 8'h00, 8'h41) then (8'h01, 8'h42) on consecutive cycles; cursor=(2,0).
3. Cursor at (31,0), send 'Z' -> write addr 8'h1F data 8'h5A; cursor=(0,1). At (31,7), send 'Q' -> write addr 8'hFF; cursor=(0,0).
4. Cursor at (5,2), send CR then LF -> no writes; cursor (0,2) then (0,3). Then BS at (0,3) -> write addr {3'd2,5'd31}=8'h5F data 8'h20, cursor=(31,2). BS at (0,0) -> no write.
5. Mid-stream FF with in_valid held high on the next byte -> in_ready low, the 256-write clear runs, the held byte is accepted only after busy falls, and it is written at addr 8'h00.
6. Assert rst at clear address 100 -> outputs drop to reset values immediately. After release, the clear restarts at address 0 and completes all 256 writes.

Source files
------------

// File: rtl/char_buffer_writer.sv
// rtl/char_buffer_writer.sv - character RAM writer for the on-screen text buffer
//
// Accepts a byte stream over in_valid/in_ready. The block writes printable codes
// into a 256-entry character RAM at {row, col}. It interprets CR, LF, BS and FF,
// and blanks the whole RAM after reset and on form-feed.
//
// Ports:
//   pclk      pixel clock, rising edge
//   rst       asynchronous active-low reset
//   in_data   character or control byte
//   in_valid  in_data is valid
//   in_ready  byte can be accepted this cycle (IDLE only)
//   wr_en     RAM write strobe, one-cycle pulse per write
//   wr_addr   RAM address {row[2:0], col[4:0]}
//   wr_data   character code to write
//   cursor_x  cursor column (next write position)
//   cursor_y  cursor row (next write position)
//   busy      clear in progress

module char_buffer_writer #(
   parameter int         COLS       = 32,
   parameter int         ROWS       = 8,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [4:0] cursor_x,
   output logic [2:0] cursor_y,
   output logic       busy
);

   localparam int CELLS = COLS * ROWS;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t     state;
   // One bit wider than the address so the terminal count (all cells written) is visible.
   logic [8:0] clr_cnt;
   logic       accept;
   logic       printable;
   logic       bs_moves;
   logic [4:0] bs_x;
   logic [2:0] bs_y;

   assign in_ready  = (state == IDLE);
   assign busy      = (state == CLEAR);
   assign accept    = in_valid && in_ready;
   assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

   // Backspace target: step left, or to the last column of the previous row.
   always_comb begin
      bs_moves = 1'b1;
      bs_x     = cursor_x;
      bs_y     = cursor_y;
      if (cursor_x != 5'd0) begin
         bs_x = cursor_x - 5'd1;
      end else if (cursor_y != 3'd0) begin
         bs_x = 5'(COLS - 1);
         bs_y = cursor_y - 3'd1;
      end else begin
         bs_moves = 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state    <= CLEAR;
         clr_cnt  <= 9'd0;
         cursor_x <= 5'd0;
         cursor_y <= 3'd0;
         wr_en    <= 1'b0;
         wr_addr  <= 8'd0;
         wr_data  <= 8'd0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            CLEAR: begin
               // The state leaves CLEAR one cycle after the last address is driven.
               if (clr_cnt == 9'(CELLS)) begin
                  state <= IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= clr_cnt[7:0];
                  wr_data <= BLANK_CHAR;
                  clr_cnt <= clr_cnt + 9'd1;
               end
            end
            IDLE: begin
               if (accept) begin
                  if (printable) begin
                     wr_en   <= 1'b1;
                     wr_addr <= {cursor_y, cursor_x};
                     wr_data <= in_data;
                     if (cursor_x == 5'(COLS - 1)) begin
                        cursor_x <= 5'd0;
                        cursor_y <= (cursor_y == 3'(ROWS - 1)) ? 3'd0 : cursor_y + 3'd1;
                     end else begin
                        cursor_x <= cursor_x + 5'd1;
                     end
                  end else begin
                     case (in_data)
                        8'h0D: cursor_x <= 5'd0;
                        8'h0A: cursor_y <= cursor_y + 3'd1;
                        8'h08: begin
                           if (bs_moves) begin
                              wr_en    <= 1'b1;
                              wr_addr  <= {bs_y, bs_x};
                              wr_data  <= BLANK_CHAR;
                              cursor_x <= bs_x;
                              cursor_y <= bs_y;
                           end
                        end
                        8'h0C: begin
                           cursor_x <= 5'd0;
                           cursor_y <= 3'd0;
                           clr_cnt  <= 9'd0;
                           state    <= CLEAR;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
